// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with fixed-latency block refill and saturating hit/miss counters.
// Hits return the instruction combinationally; a miss stalls for MISS_LATENCY+2 cycles.
module inst_cache #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned BLOCK_SIZE   = 16,
    parameter int unsigned LINES        = 8,
    parameter int unsigned MISS_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req,
    input  logic [WORD_SIZE-1:0]            ptr,
    input  logic                            flush,
    output logic [WORD_SIZE-1:0]            inst,
    output logic                            stall,
    output logic                            mem_rd,
    output logic [WORD_SIZE-1:0]            mem_ptr,
    input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block,
    output logic [31:0]                     hit_count,
    output logic [31:0]                     miss_count
);

    localparam int unsigned OFF_W = $clog2(BLOCK_SIZE);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = WORD_SIZE - OFF_W - IDX_W;
    localparam int unsigned BLK_W = WORD_SIZE - OFF_W;
    localparam int unsigned CNT_W = $clog2(MISS_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, MISS, FILL} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [WORD_SIZE-1:0]   data_q [LINES][BLOCK_SIZE];
    logic [WORD_SIZE-1:0]   fill_words [BLOCK_SIZE];
    logic [BLK_W-1:0]       miss_blk_q;
    logic [CNT_W-1:0]       wait_q;

    logic [OFF_W-1:0]       req_off;
    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       miss_idx;
    logic [TAG_W-1:0]       miss_tag;
    logic                   hit_c;
    logic                   idle_req_c;
    logic                   fill_we;

    assign req_off    = ptr[OFF_W-1:0];
    assign req_idx    = ptr[OFF_W +: IDX_W];
    assign req_tag    = ptr[WORD_SIZE-1 -: TAG_W];
    assign miss_idx   = miss_blk_q[IDX_W-1:0];
    assign miss_tag   = miss_blk_q[BLK_W-1 -: TAG_W];
    assign hit_c      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign idle_req_c = (state_q == IDLE) && req && !flush;
    assign fill_we    = (state_q == FILL) && !flush;

    // Word 0 of the memory block sits in the MSBs.
    for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_unpack
        assign fill_words[k] = mem_block[WORD_SIZE*(BLOCK_SIZE-k)-1 -: WORD_SIZE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Flush wins over every transition, aborting any refill in flight.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req && !hit_c) state_d = MISS;
                MISS:    if (wait_q <= CNT_W'(1)) state_d = FILL;
                FILL:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs held quiet while reset is asserted so they drop before the next edge.
    always_comb begin
        inst    = '0;
        stall   = 1'b0;
        mem_rd  = 1'b0;
        mem_ptr = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (flush || !hit_c) stall = 1'b1;
                        else                 inst  = data_q[req_idx][req_off];
                    end
                end
                MISS, FILL: begin
                    stall   = 1'b1;
                    mem_rd  = 1'b1;
                    mem_ptr = {miss_blk_q, OFF_W'(0)};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            miss_blk_q <= '0;
            wait_q     <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (flush)        valid_q <= '0;
            else if (fill_we) valid_q[miss_idx] <= 1'b1;

            if (idle_req_c && !hit_c) begin
                miss_blk_q <= ptr[WORD_SIZE-1:OFF_W];
                wait_q     <= CNT_W'(MISS_LATENCY);
            end else if (state_q == MISS && wait_q != '0) begin
                wait_q <= wait_q - CNT_W'(1);
            end

            if (idle_req_c && hit_c && hit_count != '1)   hit_count  <= hit_count + 32'd1;
            if (idle_req_c && !hit_c && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end

    // Line payload and tags carry no reset; valid_q guards them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= fill_words;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus randomized fetches
// checked against an array-based cache model and a synthetic instruction memory.
module tb_inst_cache;

    localparam int unsigned W   = 32;
    localparam int unsigned B   = 16;
    localparam int unsigned L   = 8;
    localparam int unsigned LAT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic [W-1:0]   ptr;
    logic           flush;
    logic [W-1:0]   inst;
    logic           stall;
    logic           mem_rd;
    logic [W-1:0]   mem_ptr;
    logic [W*B-1:0] mem_block;
    logic [W*B-1:0] blk_tmp;
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;

    int checks = 0;
    int errors = 0;

    bit          mv [L];
    logic [31:0] mt [L];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;

    inst_cache #(.WORD_SIZE(W), .BLOCK_SIZE(B), .LINES(L), .MISS_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .ptr(ptr), .flush(flush),
        .inst(inst), .stall(stall), .mem_rd(mem_rd), .mem_ptr(mem_ptr),
        .mem_block(mem_block), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h23) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Instruction memory: block at mem_ptr, word 0 ends up in the MSBs.
    always_comb begin
        blk_tmp = '0;
        for (int k = 0; k < B; k++)
            blk_tmp = {blk_tmp[W*(B-1)-1:0], mem_word(mem_ptr + 32'(k))};
        mem_block = blk_tmp;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_clear_lines();
        for (int i = 0; i < L; i++) mv[i] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_lines();
        exp_hits   = '0;
        exp_misses = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; flush = 1'b0; ptr = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge with req/ptr applied; follows the request until it is served.
    task automatic check_fetch(input logic [31:0] a);
        int          stalls;
        int          bad_ptr;
        int          idx;
        int          exp_stalls;
        logic [31:0] tg;
        bit          mhit;
        stalls  = 0;
        bad_ptr = 0;
        idx     = int'((a / B) % L);
        tg      = a / (B * L);
        mhit    = mv[idx] && (mt[idx] == tg);
        exp_stalls = mhit ? 0 : int'(LAT) + 2;
        #1;
        while (stall === 1'b1 && stalls < 20) begin
            if (mem_rd === 1'b1 && mem_ptr !== (a & ~32'hF)) bad_ptr++;
            stalls++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL stall_cycles ptr=%h got %0d expected %0d", a, stalls, exp_stalls);
        end
        checks++;
        if (inst !== mem_word(a)) begin
            errors++;
            $display("FAIL inst ptr=%h got %h expected %h", a, inst, mem_word(a));
        end
        checks++;
        if (bad_ptr != 0) begin
            errors++;
            $display("FAIL mem_ptr ptr=%h got %0d bad cycles expected 0", a, bad_ptr);
        end
        if (!mhit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            if (exp_misses != 32'hFFFFFFFF) exp_misses++;
        end
        if (exp_hits != 32'hFFFFFFFF) exp_hits++;
    endtask

    task automatic run_fetch(input logic [31:0] a);
        @(negedge clk);
        req = 1'b1; ptr = a; flush = 1'b0;
        check_fetch(a);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || inst !== '0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs got stall=%b inst=%h mem_rd=%b expected 0 0 0", stall, inst, mem_rd);
        end
    endtask

    task automatic check_counters(input string tag);
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            errors++;
            $display("FAIL counters_%s got hit=%h miss=%h expected hit=%h miss=%h",
                     tag, hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; flush = 1'b0; ptr = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || inst !== '0 || mem_rd !== 1'b0 || mem_ptr !== '0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%b inst=%h mem_rd=%b mem_ptr=%h expected all 0",
                     stall, inst, mem_rd, mem_ptr);
        end
        checks++;
        if (hit_count !== '0 || miss_count !== '0) begin
            errors++;
            $display("FAIL reset_counters got hit=%h miss=%h expected 0 0", hit_count, miss_count);
        end
        rst = 1'b0;
        model_reset();
        idle_cycle();
    endtask

    task automatic test_cold_miss();
        run_fetch(32'h23);
        idle_cycle();
        check_counters("cold");
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL cold_counts got hit=%0d miss=%0d expected 1 1", hit_count, miss_count);
        end
    endtask

    task automatic test_spatial();
        for (int a = 32'h20; a <= 32'h2F; a++) run_fetch(32'(a));
        idle_cycle();
        checks++;
        if (hit_count !== 32'd17 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL spatial_counts got hit=%0d miss=%0d expected 17 1", hit_count, miss_count);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        run_fetch(32'h05);
        run_fetch(32'h85);
        run_fetch(32'h05);
        idle_cycle();
        checks++;
        if (miss_count !== 32'd3) begin
            errors++;
            $display("FAIL conflict_misses got %0d expected 3", miss_count);
        end
        check_counters("conflict");
    endtask

    task automatic test_flush();
        @(negedge clk);
        req = 1'b0; flush = 1'b1;
        model_clear_lines();
        run_fetch(32'h05);
        // Flush on the second MISS cycle of a fresh miss.
        @(negedge clk);
        req = 1'b1; ptr = 32'h95; flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_first_miss stall got %b expected 1", stall);
        end
        if (exp_misses != 32'hFFFFFFFF) exp_misses++;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_miss stall got %b expected 1", stall);
        end
        model_clear_lines();
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || mem_ptr !== '0) begin
            errors++;
            $display("FAIL flush_abort got mem_rd=%b mem_ptr=%h expected 0 0", mem_rd, mem_ptr);
        end
        check_fetch(32'h95);
        run_fetch(32'h05);
        idle_cycle();
        check_counters("flush");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req = 1'b1; ptr = 32'h1F3; flush = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_outputs got mem_rd=%b stall=%b expected 0 0", mem_rd, stall);
        end
        checks++;
        if (hit_count !== '0 || miss_count !== '0) begin
            errors++;
            $display("FAIL async_reset_counters got hit=%h miss=%h expected 0 0", hit_count, miss_count);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        model_reset();
        run_fetch(32'h1F3);
        idle_cycle();
        check_counters("async_reset");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
        force dut.hit_count = 32'hFFFFFFFE;
        #1;
        release dut.hit_count;
        exp_hits = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) run_fetch(32'h1F0 + 32'(i));
        idle_cycle();
        checks++;
        if (hit_count !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL hit_saturation got %h expected ffffffff", hit_count);
        end
        check_counters("saturation");
    endtask

    task automatic test_random();
        int unsigned r;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                idle_cycle();
            end else if (r == 1) begin
                @(negedge clk);
                req = $urandom_range(0, 1) == 1;
                ptr = 32'($urandom_range(0, 32'h3FF));
                flush = 1'b1;
                #1;
                checks++;
                if (stall !== req || inst !== '0) begin
                    errors++;
                    $display("FAIL flush_stall req=%b got stall=%b inst=%h expected stall=%b inst=0",
                             req, stall, inst, req);
                end
                model_clear_lines();
            end else begin
                run_fetch(32'($urandom_range(0, 32'h3FF)));
            end
        end
        idle_cycle();
        check_counters("random");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial();
        test_conflict();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
